// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the pipeline
// writeback and a small buffer of multiply/divide (MDU) results. It also keeps a
// scoreboard of registers whose MDU result is still outstanding.
//
// Ports:
//   clk, rst                     clock (posedge), asynchronous active-high reset
//   wb_we/wb_rd/wb_wd            pipeline writeback request (wb_rd=0 means no request)
//   mdu_issue/mdu_rd             MDU op issued; marks mdu_rd busy
//   mdu_done/_rd/_wd             MDU result, pushed into the buffer when mdu_ready
//   rs_a1/rs_a2                  decode-stage source registers, drive stall
//   RFWr/A3/WD                   register file write port (all zero when RFWr=0)
//   mdu_ready                    buffer has room this cycle
//   stall                        a decode source register is busy
//   wb_hold                      writeback blocked so the starving buffer head can drain
//   busy_vec                     scoreboard, bit r set while r awaits an MDU result
module rf_wb_arbiter #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_wd,
   input  logic        mdu_issue,
   input  logic [4:0]  mdu_rd,
   input  logic        mdu_done,
   input  logic [4:0]  mdu_done_rd,
   input  logic [31:0] mdu_done_wd,
   input  logic [4:0]  rs_a1,
   input  logic [4:0]  rs_a2,
   output logic        RFWr,
   output logic [4:0]  A3,
   output logic [31:0] WD,
   output logic        mdu_ready,
   output logic        stall,
   output logic        wb_hold,
   output logic [31:0] busy_vec
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned StW  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   localparam logic [PtrW-1:0] LastPtr   = PtrW'(FIFO_DEPTH - 1);
   localparam logic [CntW-1:0] FullCnt   = CntW'(FIFO_DEPTH);
   localparam logic [StW-1:0]  StarveMax = StW'(STARVE_MAX);

   logic [4:0]      r_buf_rd [FIFO_DEPTH];
   logic [31:0]     r_buf_wd [FIFO_DEPTH];
   logic [PtrW-1:0] r_head;
   logic [PtrW-1:0] r_tail;
   logic [CntW-1:0] r_count;
   logic [StW-1:0]  r_starve;
   logic [31:0]     r_busy;

   logic            w_empty;
   logic            w_wb_req;
   logic            w_pop;
   logic            w_push;
   logic [4:0]      w_head_rd;
   logic [31:0]     w_head_wd;
   logic [StW-1:0]  w_starve_nxt;
   logic [31:0]     w_busy_nxt;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      w_empty   = (r_count == '0);
      w_wb_req  = wb_we && (wb_rd != 5'd0);
      w_head_rd = r_buf_rd[r_head];
      w_head_wd = r_buf_wd[r_head];
      mdu_ready = (r_count < FullCnt);
      wb_hold   = (r_starve == StarveMax) && !w_empty;
      // The head drains whenever the writeback is absent or being held off.
      w_pop     = !rst && !w_empty && (!w_wb_req || wb_hold);
      // A push never bypasses to the port: the entry is only visible from the next cycle.
      w_push    = !rst && mdu_done && mdu_ready;
   end

   // Write port; reset forces it idle even though the wb inputs are live.
   always_comb begin
      RFWr = 1'b0;
      A3   = 5'd0;
      WD   = 32'd0;
      if (rst) begin
         RFWr = 1'b0;
      end else if (w_wb_req && !wb_hold) begin
         RFWr = 1'b1;
         A3   = wb_rd;
         WD   = wb_wd;
      end else if (w_pop && (w_head_rd != 5'd0)) begin
         // An x0 result is still popped, it just produces no write.
         RFWr = 1'b1;
         A3   = w_head_rd;
         WD   = w_head_wd;
      end
   end

   always_comb begin
      w_starve_nxt = r_starve;
      if (w_empty || w_pop) begin
         w_starve_nxt = '0;
      end else if (r_starve != StarveMax) begin
         w_starve_nxt = r_starve + 1'b1;
      end
   end

   // Clear first, then set, so a new issue wins over the retiring entry.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_pop && (w_head_rd != 5'd0)) begin
         w_busy_nxt[w_head_rd] = 1'b0;
      end
      if (mdu_issue && (mdu_rd != 5'd0)) begin
         w_busy_nxt[mdu_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_comb begin
      busy_vec = r_busy;
      stall    = ((rs_a1 != 5'd0) && r_busy[rs_a1]) || ((rs_a2 != 5'd0) && r_busy[rs_a2]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_starve <= '0;
         r_busy   <= '0;
      end else begin
         if (w_push) begin
            r_tail <= ptr_inc(r_tail);
         end
         if (w_pop) begin
            r_head <= ptr_inc(r_head);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_starve <= w_starve_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   // Payload storage needs no reset: occupancy is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf_rd[r_tail] <= mdu_done_rd;
         r_buf_wd[r_tail] <= mdu_done_wd;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus randomized traffic for rf_wb_arbiter,
// checked every cycle against a queue-based reference model.
module tb_rf_wb_arbiter;

   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned STARVE_MAX = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_wd;
   logic        mdu_issue;
   logic [4:0]  mdu_rd;
   logic        mdu_done;
   logic [4:0]  mdu_done_rd;
   logic [31:0] mdu_done_wd;
   logic [4:0]  rs_a1;
   logic [4:0]  rs_a2;
   logic        RFWr;
   logic [4:0]  A3;
   logic [31:0] WD;
   logic        mdu_ready;
   logic        stall;
   logic        wb_hold;
   logic [31:0] busy_vec;

   always #5 clk = ~clk;

   rf_wb_arbiter #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .STARVE_MAX(STARVE_MAX)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_wd      (wb_wd),
      .mdu_issue  (mdu_issue),
      .mdu_rd     (mdu_rd),
      .mdu_done   (mdu_done),
      .mdu_done_rd(mdu_done_rd),
      .mdu_done_wd(mdu_done_wd),
      .rs_a1      (rs_a1),
      .rs_a2      (rs_a2),
      .RFWr       (RFWr),
      .A3         (A3),
      .WD         (WD),
      .mdu_ready  (mdu_ready),
      .stall      (stall),
      .wb_hold    (wb_hold),
      .busy_vec   (busy_vec)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] wd;
   } ent_t;

   // Reference model: pending results in arrival order, blocked-cycle count, busy set.
   ent_t        m_q[$];
   int unsigned m_starve;
   logic [31:0] m_busy;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic model_req();
      return wb_we && (wb_rd != 5'd0);
   endfunction

   function automatic logic model_hold();
      return (m_starve == STARVE_MAX) && (m_q.size() > 0);
   endfunction

   function automatic logic model_pop();
      return (m_q.size() > 0) && (!model_req() || model_hold());
   endfunction

   task automatic check_outputs();
      logic        e_we;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      logic        e_stall;
      e_we = 1'b0;
      e_a3 = 5'd0;
      e_wd = 32'd0;
      if (!rst) begin
         if (model_req() && !model_hold()) begin
            e_we = 1'b1;
            e_a3 = wb_rd;
            e_wd = wb_wd;
         end else if (model_pop() && m_q[0].rd != 5'd0) begin
            e_we = 1'b1;
            e_a3 = m_q[0].rd;
            e_wd = m_q[0].wd;
         end
      end
      e_stall = ((rs_a1 != 5'd0) && m_busy[rs_a1]) || ((rs_a2 != 5'd0) && m_busy[rs_a2]);
      check_eq("RFWr", RFWr, e_we);
      check_eq("A3", A3, e_a3);
      check_eq("WD", WD, e_wd);
      check_eq("mdu_ready", mdu_ready, m_q.size() < FIFO_DEPTH);
      check_eq("stall", stall, e_stall);
      check_eq("wb_hold", wb_hold, model_hold());
      check_eq("busy_vec", busy_vec, m_busy);
   endtask

   task automatic model_update();
      logic was_empty;
      logic pop;
      logic room;
      ent_t e;
      was_empty = (m_q.size() == 0);
      pop       = model_pop();
      room      = (m_q.size() < FIFO_DEPTH);
      if (pop) begin
         e = m_q.pop_front();
         if (e.rd != 5'd0) m_busy[e.rd] = 1'b0;
      end
      if (mdu_done && room) m_q.push_back({mdu_done_rd, mdu_done_wd});
      if (was_empty || pop) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
      if (mdu_issue && mdu_rd != 5'd0) m_busy[mdu_rd] = 1'b1;
   endtask

   // Called at posedge+1; checks before the next edge, then advances the model.
   task automatic cycle();
      #3;
      check_outputs();
      @(posedge clk);
      if (!rst) model_update();
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                        input logic iss, input logic [4:0] ird,
                        input logic dn, input logic [4:0] drd, input logic [31:0] dwd,
                        input logic [4:0] a1, input logic [4:0] a2);
      wb_we       = we;
      wb_rd       = rd;
      wb_wd       = wd;
      mdu_issue   = iss;
      mdu_rd      = ird;
      mdu_done    = dn;
      mdu_done_rd = drd;
      mdu_done_wd = dwd;
      rs_a1       = a1;
      rs_a2       = a2;
   endtask

   // Asserted mid-cycle to exercise the asynchronous path; released away from an edge.
   task automatic pulse_reset();
      rst = 1'b1;
      m_q.delete();
      m_starve = 0;
      m_busy   = '0;
      #1;
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      m_starve = 0;
      m_busy   = '0;
      drive(1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      #2;
      check_outputs();
      check_eq("rst_rfwr", RFWr, 1'b0);
      check_eq("rst_ready", mdu_ready, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Plain writeback with empty buffer.
      drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      #1;
      check_eq("wb_a3", A3, 32'd5);
      check_eq("wb_wd", WD, 32'h1234);
      cycle();

      // Issue, stall, completion, release.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd8, 32'hCAFE, 5'd8, 5'd0);
      #1;
      check_eq("iss_stall", stall, 1'b1);
      check_eq("iss_busy", busy_vec, 32'h100);
      check_eq("no_bypass", RFWr, 1'b0);
      cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0);
      #1;
      check_eq("done_rfwr", RFWr, 1'b1);
      check_eq("done_a3", A3, 32'd8);
      check_eq("done_wd", WD, 32'hCAFE);
      cycle();
      #1;
      check_eq("clr_busy", busy_vec, 32'd0);
      check_eq("clr_stall", stall, 1'b0);
      cycle();

      // wb_rd=0 counts as no request, so the buffer head gets the port.
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h77, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      #1;
      check_eq("x0_a3", A3, 32'd3);
      check_eq("x0_wd", WD, 32'h77);
      cycle();

      // Fill the buffer under continuous writeback and wait for starvation hold.
      drive(1'b1, 5'd1, 32'hA1, 1'b0, 5'd0, 1'b1, 5'd10, 32'hA, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd1, 32'hA2, 1'b0, 5'd0, 1'b1, 5'd11, 32'hB, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd1, 32'hA3, 1'b0, 5'd0, 1'b1, 5'd12, 32'hC, 5'd0, 5'd0);
      #1;
      check_eq("full_ready", mdu_ready, 1'b0);
      cycle();
      drive(1'b1, 5'd1, 32'hA4, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      cycle();
      #1;
      check_eq("starve_hold", wb_hold, 1'b1);
      check_eq("starve_a3", A3, 32'd10);
      cycle();
      #1;
      check_eq("hold_drop", wb_hold, 1'b0);
      check_eq("hold_drop_a3", A3, 32'd1);
      cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      cycle();

      // Re-issue of rd=9 in the same cycle its old result retires.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
      cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      cycle();
      #1;
      check_eq("set_wins", busy_vec[9], 1'b1);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd9, 32'h9A, 5'd0, 5'd0);
      cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      cycle();
      cycle();

      // Reset with two buffered entries pending.
      drive(1'b1, 5'd2, 32'h1, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd9, 1'b1, 5'd8, 32'h800, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd2, 32'h3, 1'b0, 5'd0, 1'b1, 5'd9, 32'h900, 5'd0, 5'd0);
      cycle();
      #1;
      check_eq("pre_rst_busy", busy_vec, 32'h300);
      pulse_reset();
      check_eq("post_rst_ready", mdu_ready, 1'b1);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd9);
      for (int i = 0; i < 4; i++) cycle();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(9) < 6, 5'($urandom_range(7)), $urandom,
               $urandom_range(9) < 3, 5'($urandom_range(12)),
               $urandom_range(9) < 5, 5'($urandom_range(12)), $urandom,
               5'($urandom_range(12)), 5'($urandom_range(12)));
         if ($urandom_range(149) == 0) pulse_reset();
         else cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, meaning MDU result buffer depth (entries).
REQ-002 The block SHALL have parameter STARVE_MAX, default 3, meaning cycles a pending MDU result may be blocked before WB is held.
REQ-003 The block SHALL have clk  input  1  clock; all state updates on posedge.
REQ-004 The block SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have wb_we / wb_rd / wb_wd  input  1/5/32  pipeline writeback request, destination, data.
REQ-006 The block SHALL have mdu_issue / mdu_rd  input  1/5  MDU operation issued, destination register.
REQ-007 The block SHALL have mdu_done / mdu_done_rd / mdu_done_wd  input  1/5/32  MDU result valid, destination, data.
REQ-008 The block SHALL have rs_a1 / rs_a2  input  5/5  decode-stage source register numbers.
REQ-009 The block SHALL have RFWr / A3 / WD  output  1/5/32  register file write port (enable, address, data).
REQ-010 The block SHALL have mdu_ready  output  1  buffer can accept mdu_done this cycle.
REQ-011 The block SHALL have stall  output  1  decode must stall (source pending in MDU).
REQ-012 The block SHALL have wb_hold  output  1  pipeline writeback must be held this cycle.
REQ-013 The block SHALL have busy_vec  output  32  scoreboard, bit r = register r has a pending MDU result.

Function
REQ-014 Write-port outputs SHALL be combinational from current state and inputs; RFWr=0 implies A3=0, WD=0.
REQ-015 wb request is effective only when wb_we=1 and wb_rd!=0; wb_rd=0 SHALL be treated as no request.
REQ-016 When wb_hold=0 and wb request effective: port = {1, wb_rd, wb_wd}; buffer not popped.
REQ-017 When no effective wb request or wb_hold=1, and buffer non-empty: port = head entry; head popped at next posedge.
REQ-018 Otherwise RFWr=0.
REQ-019 Buffer: FIFO of FIFO_DEPTH entries {rd, wd}; mdu_ready = (count < FIFO_DEPTH); push at posedge when mdu_done && mdu_ready; mdu_done with mdu_ready=0 SHALL be ignored.
REQ-020 A pushed entry SHALL NOT reach the port in its push cycle (no bypass); earliest write is next cycle.
REQ-021 Simultaneous push and pop SHALL be legal when count<FIFO_DEPTH; count unchanged.
REQ-022 mdu_done_rd=0 SHALL be pushed and popped normally but drive RFWr=0 for that pop.
REQ-023 Starve counter: increments at posedge when buffer non-empty and no pop; clears on pop or empty; saturates at STARVE_MAX.
REQ-024 wb_hold = (starve == STARVE_MAX) && buffer non-empty; port then serves buffer head regardless of wb request.
REQ-025 Scoreboard: busy[r] set at posedge when mdu_issue && mdu_rd==r && r!=0.
REQ-026 busy[r] cleared at posedge when head entry with rd==r is popped; set SHALL win over clear in the same cycle.
REQ-027 Writeback writes SHALL NOT modify the scoreboard; busy_vec[0] SHALL always be 0.
REQ-028 stall = (rs_a1!=0 && busy[rs_a1]) || (rs_a2!=0 && busy[rs_a2]); combinational.

Reset
REQ-029 While rst=1 (asynchronously): buffer empty, starve=0, busy_vec=0, RFWr=0, A3=0, WD=0, wb_hold=0, stall=0, mdu_ready=1.
REQ-030 Reset mid-operation SHALL discard all buffered results and pending busy bits; no write issued for them.

Verification
REQ-031 wb_we=1, wb_rd=5, wb_wd=0x1234, buffer empty -> same cycle RFWr=1, A3=5, WD=0x1234.
REQ-032 mdu_issue rd=8; next cycle rs_a1=8 -> stall=1, busy_vec=0x00000100; mdu_done rd=8 wd=0xCAFE with wb idle -> next cycle RFWr=1, A3=8, WD=0xCAFE; following cycle busy_vec=0, stall=0.
REQ-033 Two mdu_done pushes with wb continuously writing -> mdu_ready=0 after second push; third mdu_done ignored; after 3 blocked cycles wb_hold=1 and head written; wb_hold drops after pop if counter cleared.
REQ-034 mdu_issue rd=9 in same cycle head entry rd=9 pops -> busy_vec[9]=1 afterwards.
REQ-035 wb_we=1, wb_rd=0 with buffer entry rd=3 wd=0x77 -> RFWr=1, A3=3, WD=0x77.
REQ-036 rst pulsed with 2 buffered entries and busy_vec=0x00000300 -> immediately RFWr=0, busy_vec=0, mdu_ready=1; no later writes of those entries.
